// File: rtl/quickq_req_arbiter.sv
// Round-robin front end that lets NREQ requesters share one QuickQ queue controller.
// Tracks occupancy locally so illegal enq/deq are rejected without touching the controller.
module quickq_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 255,
  localparam int IW     = $clog2(NREQ),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               resp_valid,
  output logic [IW-1:0]      resp_id,
  output logic [DW-1:0]      resp_data,
  output logic [1:0]         resp_err,
  output logic               q_enq,
  output logic               q_deq,
  output logic [DW-1:0]      q_data,
  input  logic               q_done,
  input  logic [DW-1:0]      q_rd_data,
  output logic [CW-1:0]      count,
  output logic               q_full,
  output logic               q_empty
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEPTH);
  localparam logic [IW-1:0] ID_LAST   = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [IW-1:0]       rr_ptr_r, rr_ptr_s;
  logic [CW-1:0]       count_r, count_s;
  logic                op_r, op_s;
  logic [DW-1:0]       data_r, data_s;
  logic [IW-1:0]       id_r, id_s;
  logic [1:0]          err_r, err_s;
  logic [DW-1:0]       rdata_r, rdata_s;
  logic [WW-1:0]       wdog_r, wdog_s;
  logic [NREQ-1:0]     req_ready_s;
  logic                any_valid_s;
  logic [IW-1:0]       grant_s;
  logic                full_s;
  logic                empty_s;

  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return (sum >= NREQ) ? IW'(sum - NREQ) : IW'(sum);
  endfunction

  assign full_s  = (count_r == CNT_MAX);
  assign empty_s = (count_r == {CW{1'b0}});

  // Round-robin search: first valid requester starting at rr_ptr
  always_comb begin
    any_valid_s = 1'b0;
    grant_s     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_valid_s && req_valid[rr_index(rr_ptr_r, i)]) begin
        any_valid_s = 1'b1;
        grant_s     = rr_index(rr_ptr_r, i);
      end else begin
        any_valid_s = any_valid_s;
      end
    end
  end

  // Next-state and datapath update for the request FSM
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    count_s     = count_r;
    op_s        = op_r;
    data_s      = data_r;
    id_s        = id_r;
    err_s       = err_r;
    rdata_s     = rdata_r;
    wdog_s      = wdog_r;
    req_ready_s = '0;
    case (state_r)
      S_IDLE: begin
        if (any_valid_s) begin
          req_ready_s[grant_s] = 1'b1;
          op_s     = req_op[grant_s];
          data_s   = req_data[int'(grant_s)*DW +: DW];
          id_s     = grant_s;
          rdata_s  = '0;
          rr_ptr_s = (grant_s == ID_LAST) ? {IW{1'b0}} : grant_s + IW'(1);
          if (!req_op[grant_s] && full_s) begin
            err_s   = 2'b01;
            state_s = S_RESP;
          end else if (req_op[grant_s] && empty_s) begin
            err_s   = 2'b10;
            state_s = S_RESP;
          end else begin
            err_s   = 2'b00;
            state_s = S_ISSUE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        wdog_s  = '0;
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (q_done) begin
          if (op_r) begin
            count_s = count_r - CW'(1);
            rdata_s = q_rd_data;
          end else begin
            count_s = count_r + CW'(1);
          end
          err_s   = 2'b00;
          state_s = S_RESP;
        end else if (wdog_r == WDOG_LAST) begin
          err_s   = 2'b11;
          state_s = S_RESP;
        end else begin
          wdog_s = wdog_r + WW'(1);
        end
      end
      S_RESP: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latched request, occupancy and watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
      count_r  <= '0;
      op_r     <= 1'b0;
      data_r   <= '0;
      id_r     <= '0;
      err_r    <= 2'b00;
      rdata_r  <= '0;
      wdog_r   <= '0;
    end else begin
      rr_ptr_r <= rr_ptr_s;
      count_r  <= count_s;
      op_r     <= op_s;
      data_r   <= data_s;
      id_r     <= id_s;
      err_r    <= err_s;
      rdata_r  <= rdata_s;
      wdog_r   <= wdog_s;
    end
  end

  assign req_ready  = req_ready_s;
  assign q_enq      = (state_r == S_ISSUE) && !op_r;
  assign q_deq      = (state_r == S_ISSUE) && op_r;
  assign q_data     = data_r;
  assign resp_valid = (state_r == S_RESP);
  assign resp_id    = (state_r == S_RESP) ? id_r : {IW{1'b0}};
  assign resp_err   = (state_r == S_RESP) ? err_r : 2'b00;
  // Only a successful dequeue carries data back
  assign resp_data  = ((state_r == S_RESP) && op_r && (err_r == 2'b00)) ? rdata_r : {DW{1'b0}};
  assign count      = count_r;
  assign q_full     = full_s;
  assign q_empty    = empty_s;

endmodule

// File: tb/tb_quickq_req_arbiter.sv
// Self-checking bench for quickq_req_arbiter; the bench plays the queue controller
// and predicts grants, errors and occupancy from a small behavioural model.
module tb_quickq_req_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 255;
  localparam int IW      = $clog2(NREQ);
  localparam int CW      = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_op;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic [IW-1:0]      resp_id;
  logic [DW-1:0]      resp_data;
  logic [1:0]         resp_err;
  logic               q_enq;
  logic               q_deq;
  logic [DW-1:0]      q_data;
  logic               q_done;
  logic [DW-1:0]      q_rd_data;
  logic [CW-1:0]      count;
  logic               q_full;
  logic               q_empty;

  int checks   = 0;
  int failures = 0;
  int model_cnt = 0;
  int model_rr  = 0;

  quickq_req_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .q_enq(q_enq), .q_deq(q_deq), .q_data(q_data), .q_done(q_done), .q_rd_data(q_rd_data),
    .count(count), .q_full(q_full), .q_empty(q_empty)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] m);
    for (int i = 0; i < NREQ; i++) begin
      if (m[(model_rr + i) % NREQ]) return (model_rr + i) % NREQ;
    end
    return 0;
  endfunction

  task automatic set_req(input int i, input logic op, input logic [DW-1:0] d);
    req_op[i] = op;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic pulse_reset;
    rst = 1'b1; req_valid = '0; q_done = 1'b0;
    tick;
    rst = 1'b0;
    model_cnt = 0;
    model_rr  = 0;
  endtask

  // One request from acceptance to response; expects the DUT idle on entry and leaves it idle.
  task automatic do_txn(input logic [NREQ-1:0] mask, input int delay, input bit give_done,
                        input logic [DW-1:0] rd, input bit hold);
    int g; int k; bit op; bit got; bit extra;
    logic [DW-1:0] d; logic [DW-1:0] exp_data; logic [1:0] exp_err; logic [NREQ-1:0] oh;
    req_valid = mask;
    #1;
    g  = model_grant(mask);
    op = req_op[g];
    d  = req_data[g*DW +: DW];
    oh = '0; oh[g] = 1'b1;
    checks++;
    if (req_ready !== oh) begin
      failures++; $display("FAIL grant: got %b expected %b", req_ready, oh);
    end
    if (!op && model_cnt == DEPTH)  exp_err = 2'b01;
    else if (op && model_cnt == 0)  exp_err = 2'b10;
    else if (!give_done)            exp_err = 2'b11;
    else                            exp_err = 2'b00;
    exp_data = (op && exp_err == 2'b00) ? rd : '0;
    model_rr = (g + 1) % NREQ;
    tick;
    if (!hold) req_valid = '0;
    #1;
    if (exp_err == 2'b01 || exp_err == 2'b10) begin
      checks++;
      if ({q_enq, q_deq} !== 2'b00) begin
        failures++; $display("FAIL reject_strobe: got enq=%b deq=%b expected none", q_enq, q_deq);
      end
    end else begin
      checks++;
      if ({q_enq, q_deq} !== (op ? 2'b01 : 2'b10) || q_data !== d) begin
        failures++;
        $display("FAIL strobe: got enq=%b deq=%b data=%h expected op=%0d data=%h", q_enq, q_deq, q_data, op, d);
      end
      got = 0; extra = 0; k = 0;
      while (!got && k < TIMEOUT + 10) begin
        k++;
        tick;
        q_done    = give_done && (k == delay);
        q_rd_data = (give_done && k == delay) ? rd : $urandom();
        #1;
        if (q_enq || q_deq) extra = 1;
        if (resp_valid) got = 1;
      end
      q_done = 1'b0;
      checks++;
      if (!got) begin
        failures++; $display("FAIL resp_wait: got no resp_valid expected one within %0d cycles", TIMEOUT + 10);
      end
      checks++;
      if (give_done ? (k != delay + 1) : (k < TIMEOUT || k > TIMEOUT + 2)) begin
        failures++; $display("FAIL resp_latency: got %0d cycles after strobe expected %0d", k, give_done ? delay + 1 : TIMEOUT + 1);
      end
      checks++;
      if (extra) begin
        failures++; $display("FAIL extra_strobe: got repeated strobe expected exactly one");
      end
    end
    if (exp_err == 2'b00) model_cnt += op ? -1 : 1;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== IW'(g) || resp_err !== exp_err || resp_data !== exp_data) begin
      failures++;
      $display("FAIL resp: got v=%b id=%0d err=%b data=%h expected v=1 id=%0d err=%b data=%h",
               resp_valid, resp_id, resp_err, resp_data, g, exp_err, exp_data);
    end
    checks++;
    if (count !== CW'(model_cnt) || q_full !== (model_cnt == DEPTH) || q_empty !== (model_cnt == 0)) begin
      failures++;
      $display("FAIL occupancy: got count=%0d full=%b empty=%b expected count=%0d", count, q_full, q_empty, model_cnt);
    end
    tick;
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++; $display("FAIL resp_pulse: got resp_valid=%b expected 0", resp_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; req_op = '0; req_data = '0; q_done = 1'b0; q_rd_data = '0;
    tick; tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_data, resp_err, q_enq, q_deq, q_data} !== '0 ||
        count !== '0 || q_full !== 1'b0 || q_empty !== 1'b1) begin
      failures++;
      $display("FAIL reset: got ready=%b rv=%b err=%b enq=%b deq=%b count=%0d full=%b empty=%b expected zeros with empty=1",
               req_ready, resp_valid, resp_err, q_enq, q_deq, count, q_full, q_empty);
    end
    model_cnt = 0; model_rr = 0;
  endtask

  task automatic test_first_enq;
    set_req(0, 1'b0, 32'h10);
    do_txn(4'b0001, 2, 1'b1, '0, 1'b0);
  endtask

  task automatic test_round_robin;
    pulse_reset;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, DW'(32'h100 + i));
    for (int n = 0; n < 5; n++) do_txn(4'b1111, 1, 1'b1, '0, 1'b1);
    req_valid = '0;
  endtask

  task automatic test_deq_empty;
    pulse_reset;
    set_req(1, 1'b1, $urandom());
    do_txn(4'b0010, 1, 1'b1, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_fill_full;
    while (model_cnt < DEPTH) begin
      set_req(0, 1'b0, $urandom());
      do_txn(4'b0001, 1, 1'b1, '0, 1'b0);
    end
    set_req(2, 1'b0, 32'h2222);
    do_txn(4'b0100, 1, 1'b1, '0, 1'b0);
  endtask

  task automatic test_deq_data;
    set_req(3, 1'b1, '0);
    do_txn(4'b1000, 3, 1'b1, 32'h0000_ABCD, 1'b0);
  endtask

  task automatic test_timeout;
    bit seen;
    set_req(0, 1'b0, 32'h7777);
    do_txn(4'b0001, 0, 1'b0, '0, 1'b0);
    q_done = 1'b1; q_rd_data = 32'h1234_5678;
    tick;
    q_done = 1'b0;
    seen = resp_valid || q_enq || q_deq;
    tick;
    seen = seen || resp_valid || q_enq || q_deq;
    checks++;
    if (seen || count !== CW'(model_cnt)) begin
      failures++; $display("FAIL late_done: got activity=%b count=%0d expected none count=%0d", seen, count, model_cnt);
    end
    set_req(1, 1'b1, '0);
    do_txn(4'b0010, 1, 1'b1, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_reset_in_wait;
    bit seen;
    set_req(0, 1'b0, 32'h55);
    req_valid = 4'b0001;
    tick;
    req_valid = '0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_cnt = 0; model_rr = 0;
    checks++;
    if (count !== '0 || q_empty !== 1'b1 || resp_valid !== 1'b0 || q_enq !== 1'b0 || q_deq !== 1'b0) begin
      failures++;
      $display("FAIL reset_wait: got count=%0d empty=%b rv=%b enq=%b deq=%b expected 0,1,0,0,0",
               count, q_empty, resp_valid, q_enq, q_deq);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (resp_valid || q_enq || q_deq) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL reset_wait_quiet: got activity after reset expected none");
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, DW'(i));
    do_txn(4'b1111, 1, 1'b1, '0, 1'b0);
  endtask

  task automatic test_random;
    pulse_reset;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom());
      do_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(1, 4), 1'b1, $urandom(), 1'b0);
    end
  endtask

  initial begin
    test_reset;
    test_first_enq;
    test_round_robin;
    test_deq_empty;
    test_fill_full;
    test_deq_data;
    test_timeout;
    test_reset_in_wait;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish before time limit");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/quickq_req_arbiter.md
Name: quickq_req_arbiter

Overview:
- Shares one QuickQ priority queue (its control FSM and BRAM) between NREQ requesters.
- Accepts enqueue/dequeue requests from any requester, picking one per operation by round-robin, and serializes them onto the queue controller's enq/deq strobe interface.
- Waits for the controller's completion, then returns a tagged response (dequeued data or error) to the requester.
- Tracks queue occupancy itself and rejects illegal operations (enq when full, deq when empty) without ever strobing the controller.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, data/key width.
- DEPTH, 64, queue capacity in entries.
- TIMEOUT, 255, max cycles spent in WAIT before the operation is abandoned.
- IW = $clog2(NREQ), derived, requester id width.
- CW = $clog2(DEPTH+1), derived, count width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_op  in  NREQ  per-requester op: 0 = enqueue, 1 = dequeue.
- req_data  in  NREQ*DW  per-requester enqueue key; slice i = [i*DW +: DW].
- req_ready  out  NREQ  one-hot accept pulse to the granted requester.
- resp_valid  out  1  response pulse.
- resp_id  out  IW  requester index the response belongs to.
- resp_data  out  DW  dequeued key; 0 for enqueue or on error.
- resp_err  out  2  00 ok, 01 full, 10 empty, 11 timeout.
- q_enq  out  1  one-cycle enqueue strobe to the queue controller.
- q_deq  out  1  one-cycle dequeue strobe to the queue controller.
- q_data  out  DW  enqueue key to the controller; stable from ISSUE through WAIT.
- q_done  in  1  controller completion pulse.
- q_rd_data  in  DW  controller dequeue result; valid with q_done.
- count  out  CW  current queue occupancy.
- q_full  out  1  count == DEPTH.
- q_empty  out  1  count == 0.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, rr_ptr=0, count=0.
  - All outputs 0 except q_empty=1.
  - An in-flight operation is abandoned with no response; the queue controller must be reset on the same rst.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on a rejected request.
- IDLE:
  - If any req_valid is set, grant g = first asserted index searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g]=1 for this single cycle.
  - Latch op, data slice and id=g; rr_ptr <= (g+1) mod NREQ.
  - Enq with count==DEPTH -> RESP, err=01.
  - Deq with count==0 -> RESP, err=10.
  - Otherwise -> ISSUE.
  - No req_valid: stay in IDLE; rr_ptr unchanged.
- ISSUE:
  - Exactly one of q_enq/q_deq high for one cycle; q_data = latched data.
  - Clear the watchdog counter; -> WAIT.
- WAIT:
  - Sample q_done only in this state.
  - On q_done: enq -> count+1; deq -> count-1 and capture q_rd_data; err=00; -> RESP.
  - If the watchdog reaches TIMEOUT without q_done: err=11, count unchanged, -> RESP.
- RESP:
  - resp_valid=1 for one cycle with resp_id, resp_data, resp_err; -> IDLE.
  - No response backpressure.
  - resp_data is forced to 0 unless the op was a deq with err=00.
- q_done asserted in IDLE, ISSUE or RESP is ignored, and so is a late q_done after a timeout.
- Requesters hold valid/op/data until their req_ready pulse; deasserting req_valid before the grant is legal and drops the request.
- Latency: accept at cycle T; strobe at T+1; q_done earliest at T+2; resp_valid the cycle after q_done (minimum T+3).
  - Rejected request: resp_valid at T+1.
  - Best-case throughput is one operation per 4 cycles.
- count never wraps: the reject checks guarantee 0 <= count <= DEPTH.
- q_full and q_empty are combinational from the count register.

Test Plan:
- Reset, then req 0 enq 0x10 with q_done returned 2 cycles after q_enq -> req_ready=0001 at T, q_enq=1 at T+1 with q_data=0x10, resp_valid at T+4 with id=0, err=00; count=1.
- All 4 requesters valid (enq) continuously with rr_ptr=0 -> grants in order 0,1,2,3,0; no requester is granted twice before the others are served.
- Deq while count==0 -> no q_deq strobe, resp_valid one cycle after accept with err=10, data=0; count stays 0.
- Fill to DEPTH=64, then enq from req 2 -> err=01, no q_enq strobe, q_full=1.
- Deq with q_rd_data=0xABCD on q_done -> resp_data=0xABCD, err=00, count decremented by 1.
- Withhold q_done for TIMEOUT cycles -> err=11 and count unchanged; a late q_done arriving in IDLE is ignored. Assert rst during WAIT -> state IDLE, count=0, no resp_valid.
